// File: rtl/fsm_io_pkg.sv
// fsm_io_pkg -- shared definitions for push-button input stages.
//   btn_state_e              : debounce FSM state encoding (2-bit)
//   DEBOUNCE_CYCLES_DEFAULT  : default stable-sample count for a level change
//   LONG_CYCLES_DEFAULT      : default PRESSED cycles before a long press
//   is_pressed_state()       : true for states in which the button reads as held
package fsm_io_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int unsigned LONG_CYCLES_DEFAULT     = 1024;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic logic is_pressed_state(input btn_state_e s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/click_conditioner_if.sv
// click_conditioner_if -- button-side signal bundle of click_conditioner.
//   btn_raw     : raw asynchronous button level (1 = pressed)
//   click       : single-cycle pulse per accepted press
//   pressed     : debounced button level
//   long_press  : single-cycle pulse when a press is held long enough
//   press_count : 8-bit wrapping count of accepted presses
// Modports: master drives btn_raw and observes the rest; slave is the
// conditioner itself.
interface click_conditioner_if;

  logic       btn_raw;
  logic       click;
  logic       pressed;
  logic       long_press;
  logic [7:0] press_count;

  modport master (
    output btn_raw,
    input  click,
    input  pressed,
    input  long_press,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output click,
    output pressed,
    output long_press,
    output press_count
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous level.
//   clk : sampling clock (rising edge)
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/click_conditioner.sv
// click_conditioner -- debounces a push-button and produces click pulses.
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : click_conditioner_if.slave
//          btn_raw in; click, pressed, long_press, press_count out
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples to accept a change
//   LONG_CYCLES     : PRESSED cycles before long_press pulses
// Optional feature macro CLICK_LONG_PRESS_EN: when defined, a saturating
// counter of PRESSED cycles drives long_press; otherwise long_press is 0.
module click_conditioner
  import fsm_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  click_conditioner_if.slave  bus
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("click_conditioner: DEBOUNCE_CYCLES must be in 2..65535");
  end

  if (LONG_CYCLES < 2 || LONG_CYCLES > (1 << 20)) begin : g_bad_long
    $error("click_conditioner: LONG_CYCLES must be in 2..2^20");
  end

  logic             w_btn_s;
  btn_state_e       r_state;
  btn_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_click_set;

  logic             r_click;
  logic             r_pressed;
  logic [7:0]       r_press_count;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_raw),
    .q   (w_btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_click_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = PRESSED;
          w_click_set  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 returns to PRESSED silently: no click.
        if (w_btn_s) begin
          w_state_next = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register (click high in the first PRESSED cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_click       <= 1'b0;
      r_pressed     <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_click   <= w_click_set;
      r_pressed <= is_pressed_state(w_state_next);
      if (w_click_set) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign bus.click       = r_click;
  assign bus.pressed     = r_pressed;
  assign bus.press_count = r_press_count;

`ifdef CLICK_LONG_PRESS_EN
  localparam int unsigned       LONG_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] r_long_cnt;
  logic              r_long_press;

  // Counts PRESSED cycles only; RELEASE_WAIT holds the value so a release
  // glitch does not restart the long-press timer. Saturation at LONG_LAST
  // limits the pulse to once per press until IDLE clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_long_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if (w_state_next == IDLE) begin
        r_long_cnt <= '0;
      end else if (r_state == PRESSED && r_long_cnt != LONG_LAST) begin
        r_long_cnt   <= r_long_cnt + 1'b1;
        r_long_press <= (r_long_cnt == LONG_LAST - 1'b1);
      end
    end
  end

  assign bus.long_press = r_long_press;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: doc/click_conditioner.md
CLICK_CONDITIONER -- requirements
Module: click_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronized samples required to accept a level change (legal range 2..65535).
REQ-002 SHALL have parameter LONG_CYCLES, default 1024, the number of PRESSED-state cycles before a long press is flagged (legal range 2..2^20).
REQ-003 SHALL have port clk, input, 1, system clock, with all logic clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port btn_raw, input, 1, asynchronous bouncing push-button level, where 1 means pressed.
REQ-006 SHALL have port click, output, 1, registered single-cycle pulse per accepted press, driving the click input of the downstream light FSM.
REQ-007 SHALL have port pressed, output, 1, registered debounced button level.
REQ-008 SHALL have port long_press, output, 1, registered single-cycle pulse when a press is held for LONG_CYCLES cycles.
REQ-009 SHALL have port press_count, output, 8, count of accepted presses.

Function
REQ-010 SHALL pass btn_raw through a 2-flop synchronizer; btn_s denotes the second flop's output.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with a debounce counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-012 SHALL, in IDLE, move to PRESS_WAIT with cnt=0 when btn_s=1, and otherwise stay in IDLE.
REQ-013 SHALL, in PRESS_WAIT, return to IDLE when btn_s=0, move to PRESSED when btn_s=1 and cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-014 SHALL, in PRESSED, move to RELEASE_WAIT with cnt=0 when btn_s=0.
REQ-015 SHALL, in RELEASE_WAIT, return to PRESSED without emitting a click when btn_s=1, move to IDLE when btn_s=0 and cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-016 SHALL drive pressed=1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-017 SHALL assert click for exactly one cycle, namely the first cycle in PRESSED entered from PRESS_WAIT; for a clean step on btn_raw this is DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_raw=1.
REQ-018 SHALL never assert click on any re-entry to PRESSED from RELEASE_WAIT.
REQ-019 SHALL increment press_count in the same cycle that click is asserted, wrapping from 255 to 0.
REQ-020 SHALL give any glitch on btn_s shorter than DEBOUNCE_CYCLES cycles no effect on click, pressed or press_count.
REQ-021 SHALL require a minimum spacing between two click pulses of 2*DEBOUNCE_CYCLES+2 cycles.

Reset
REQ-022 SHALL, while rst=1, set the state to IDLE, cnt to 0, both synchronizer flops to 0, click to 0, pressed to 0, long_press to 0, press_count to 0 and the long counter to 0.
REQ-023 SHALL, when rst is asserted mid-press, leave no pending click after rst deasserts; a button still held SHALL be re-debounced from IDLE and produce one click.

Configuration
REQ-024 SHALL, with macro CLICK_LONG_PRESS_EN defined, count cycles in PRESSED using a saturating counter cleared on entry to IDLE, and pulse long_press for one cycle when the count reaches LONG_CYCLES, at most once per press.
REQ-025 SHALL, with CLICK_LONG_PRESS_EN defined, hold the long counter (neither cleared nor advanced) during RELEASE_WAIT.
REQ-026 SHALL, without CLICK_LONG_PRESS_EN, tie long_press to constant 0 and instantiate no long counter.

Structure
REQ-027 SHALL take the state enum typedef (2-bit encoding IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3) and the default DEBOUNCE_CYCLES and LONG_CYCLES constants from shared package fsm_io_pkg, for reuse by sibling input stages.
REQ-028 SHALL implement the synchronizer as sub-module sync_2ff, with parameter-free 1-bit d/q ports plus clk and rst.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 SHALL cover a clean step: btn_raw 0->1 held -> click high for exactly one cycle on edge 7, pressed=1 from edge 7, press_count=1.
REQ-030 SHALL cover bounce: btn_raw 1,0,1,0,1 each for 1 cycle, then held 1 -> exactly one click, press_count=1.
REQ-031 SHALL cover a release glitch: while pressed, btn_raw=0 for 2 cycles then back to 1 -> pressed stays 1, no click, press_count unchanged.
REQ-032 SHALL cover wrap: 256 clean press/release cycles -> press_count returns to 0 and 256 click pulses are observed.
REQ-033 SHALL cover long press: with CLICK_LONG_PRESS_EN defined, hold for 30 cycles after click -> one long_press pulse 20 cycles after click; without the macro -> long_press constant 0.
REQ-034 SHALL cover reset mid-press: rst high for 1 cycle during PRESS_WAIT with btn_raw held 1 -> all outputs 0, then one click DEBOUNCE_CYCLES+3 edges after rst deasserts.
